// File: rtl/vga_timing_ctrl_if.sv
// Pixel FIFO link between the frame reader's show-ahead FIFO and the raster
// timing controller.
//
// Handshake: fifo_data is valid whenever fifo_empty is low (show-ahead). The
// controller pops by raising fifo_rd for one cycle. It only does so while
// fifo_empty is low. The word on fifo_data at that clock edge is consumed, and
// the FIFO presents the next word (or raises fifo_empty) after the edge.
interface vga_timing_ctrl_if;
    logic [23:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd;

    // Controller side: consumes words and issues pops.
    modport master (
        input  fifo_data,
        input  fifo_empty,
        output fifo_rd
    );

    // FIFO side: presents words and receives pops.
    modport slave (
        output fifo_data,
        output fifo_empty,
        input  fifo_rd
    );
endinterface

// File: rtl/vga_timing_ctrl.sv
// Programmable raster timing generator and pixel-fetch sequencer.
// It produces hs/vs/blank_n/data for the VGA serializer, all mutually aligned
// one cycle after the counters. Pixels are popped from a show-ahead FIFO during
// active video. An empty FIFO substitutes UNDERFLOW_RGB and raises a sticky
// flag without disturbing timing. Start and stop are frame-aligned.
module vga_timing_ctrl #(
    parameter int          H_ACTIVE      = 640,
    parameter int          H_FP          = 16,
    parameter int          H_SYNC        = 96,
    parameter int          H_BP          = 48,
    parameter int          V_ACTIVE      = 480,
    parameter int          V_FP          = 10,
    parameter int          V_SYNC        = 2,
    parameter int          V_BP          = 33,
    parameter int          HS_POL        = 0,
    parameter int          VS_POL        = 0,
    parameter logic [23:0] UNDERFLOW_RGB = 24'h0000FF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_enable,
    input  logic              i_underflow_clr,
    vga_timing_ctrl_if.master fifo,
    output logic [23:0]       o_data,
    output logic              o_blank_n,
    output logic              o_hs,
    output logic              o_vs,
    output logic              o_sof,
    output logic              o_busy,
    output logic              o_underflow,
    output logic [1:0]        o_state
);

    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] H_TOTAL  = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [11:0] H_LAST   = H_TOTAL - 12'd1;
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] V_TOTAL  = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [11:0] V_LAST   = V_TOTAL - 12'd1;
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [11:0] r_h_cnt;
    logic [11:0] r_v_cnt;
    logic [11:0] w_h_nxt;
    logic [11:0] w_v_nxt;

    logic w_running;
    logic w_active;
    logic w_hsync;
    logic w_vsync;
    logic w_h_last;
    logic w_v_last;
    logic w_frame_end;
    logic w_underrun;

    // Region decodes from the current counters. Nothing is active while idle.
    assign w_running   = (r_state != ST_IDLE);
    assign w_active    = w_running && (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_hsync     = w_running && (r_h_cnt >= HS_START) && (r_h_cnt < HS_END);
    assign w_vsync     = w_running && (r_v_cnt >= VS_START) && (r_v_cnt < VS_END);
    assign w_h_last    = (r_h_cnt == H_LAST);
    assign w_v_last    = (r_v_cnt == V_LAST);
    assign w_frame_end = w_h_last && w_v_last;
    assign w_underrun  = w_active && fifo.fifo_empty;

    assign fifo.fifo_rd = w_active && !fifo.fifo_empty;
    assign o_busy       = w_running;
    assign o_state      = r_state;

    // State and counter registers; counters only move while running.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_h_cnt <= 12'd0;
            r_v_cnt <= 12'd0;
        end else begin
            r_state <= w_state_nxt;
            r_h_cnt <= w_h_nxt;
            r_v_cnt <= w_v_nxt;
        end
    end

    // Next state and next counter values. A stop request lets the frame finish;
    // re-enabling before the last pixel resumes with no timing discontinuity.
    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_h_cnt;
        w_v_nxt     = r_v_cnt;

        if (w_running) begin
            if (w_h_last) begin
                w_h_nxt = 12'd0;
                w_v_nxt = w_v_last ? 12'd0 : (r_v_cnt + 12'd1);
            end else begin
                w_h_nxt = r_h_cnt + 12'd1;
            end
        end

        case (r_state)
            ST_IDLE: begin
                w_h_nxt = 12'd0;
                w_v_nxt = 12'd0;
                if (i_enable) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!i_enable) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (i_enable) begin
                    w_state_nxt = ST_RUN;
                end else if (w_frame_end) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Video outputs registered together so hs, vs, blank_n and data stay aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_data    <= 24'h0;
            o_blank_n <= 1'b0;
            o_hs      <= !HS_ON;
            o_vs      <= !VS_ON;
            o_sof     <= 1'b0;
        end else begin
            o_blank_n <= w_active;
            o_hs      <= w_hsync ? HS_ON : !HS_ON;
            o_vs      <= w_vsync ? VS_ON : !VS_ON;
            o_sof     <= w_active && (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
            if (w_active) begin
                o_data <= fifo.fifo_empty ? UNDERFLOW_RGB : fifo.fifo_data;
            end else begin
                o_data <= 24'h0;
            end
        end
    end

    // Sticky underflow flag; a new underflow beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_underflow <= 1'b0;
        end else if (w_underrun) begin
            o_underflow <= 1'b1;
        end else if (i_underflow_clr) begin
            o_underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl using the small 8x5 raster (40-cycle
// frame). A behavioural model tracks the frame position. Each cycle it pushes
// the expected registered outputs to a queue, and the queue is popped and
// compared once the DUT has clocked them out.
module tb_vga_timing_ctrl;
  localparam int W = 30;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        uclr = 1'b0;
  logic [23:0] data;
  logic        blank_n, hs, vs, sof, busy, uflow;
  logic [1:0]  st;

  vga_timing_ctrl_if fif();

  vga_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .UNDERFLOW_RGB(24'h0000FF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_enable(enable),
    .i_underflow_clr(uclr),
    .fifo(fif),
    .o_data(data),
    .o_blank_n(blank_n),
    .o_hs(hs),
    .o_vs(vs),
    .o_sof(sof),
    .o_busy(busy),
    .o_underflow(uflow),
    .o_state(st)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // model and scoreboard state
  logic [W-1:0] exp_q[$];
  int           m_state = 0;
  int           m_h = 0;
  int           m_v = 0;
  logic         m_uf = 1'b0;
  logic [23:0]  word = 24'd1;
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           last_sof = -1;
  int           rel_cyc = 0;
  bit           chk_rel = 1'b0;
  bit           rel_seen = 1'b0;

  task automatic adv();
    m_h++;
    if (m_h == 8) begin
      m_h = 0;
      m_v++;
      if (m_v == 5) m_v = 0;
    end
  endtask

  // driver: one pixel-clock cycle with the given inputs
  task automatic cycle(input logic en, input logic emp, input logic clr,
                       input logic rst, input string tag);
    logic         act, exp_rd, rd_obs, end_pt;
    logic         hs_e, vs_e, sof_e;
    logic [23:0]  data_e;
    logic [W-1:0] e, o;
    enable          = en;
    fif.fifo_empty  = emp;
    fif.fifo_data   = emp ? 24'($urandom) : word;
    uclr            = clr;
    reset           = rst;
    #1;
    act    = (m_state != 0) && (m_h < 4) && (m_v < 2);
    exp_rd = act && !emp;
    rd_obs = fif.fifo_rd;
    total++;
    assert (rd_obs === exp_rd) else begin
      bad++;
      $error("FAIL %s fifo_rd observed=%0b expected=%0b", tag, rd_obs, exp_rd);
    end
    if (rst) begin
      e       = {24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      m_state = 0;
      m_h     = 0;
      m_v     = 0;
      m_uf    = 1'b0;
    end else begin
      m_uf   = (act && emp) ? 1'b1 : (clr ? 1'b0 : m_uf);
      data_e = act ? (emp ? 24'h0000FF : word) : 24'h0;
      hs_e   = !((m_state != 0) && (m_h >= 5) && (m_h <= 6));
      vs_e   = !((m_state != 0) && (m_v == 3));
      sof_e  = act && (m_h == 0) && (m_v == 0);
      case (m_state)
        0: begin
          m_h = 0;
          m_v = 0;
          if (en) m_state = 1;
        end
        1: begin
          adv();
          if (!en) m_state = 2;
        end
        default: begin
          end_pt = (m_h == 7) && (m_v == 4);
          adv();
          if (en) m_state = 1;
          else if (end_pt) m_state = 0;
        end
      endcase
      e = {data_e, act, hs_e, vs_e, sof_e, m_uf, (m_state != 0)};
    end
    exp_q.push_back(e);

    @(posedge clk);
    cyc++;
    #1;
    if (rd_obs) word = word + 24'd1;

    // scoreboard: pop and compare what the DUT just registered
    o = {data, blank_n, hs, vs, sof, uflow, busy};
    e = exp_q.pop_front();
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s outputs{data,blank_n,hs,vs,sof,uf,busy} observed=%h expected=%h cyc=%0d",
             tag, o, e, cyc);
    end

    if (sof === 1'b1) begin
      if (last_sof >= 0) begin
        total++;
        assert ((cyc - last_sof) === 40) else begin
          bad++;
          $error("FAIL %s sof_gap observed=%0d expected=40", tag, cyc - last_sof);
        end
      end
      last_sof = cyc;
      if (chk_rel) begin
        total++;
        assert ((cyc - rel_cyc) === 2) else begin
          bad++;
          $error("FAIL %s sof_after_reset observed=%0d expected=2", tag, cyc - rel_cyc);
        end
        chk_rel  = 1'b0;
        rel_seen = 1'b1;
      end
    end
  endtask

  initial begin
    fif.fifo_empty = 1'b0;
    fif.fifo_data  = 24'd1;
    @(posedge clk);
    #1;

    // reset values
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1, "reset");
    last_sof = -1;

    // continuous run, FIFO always full of incrementing words
    repeat (100) cycle(1'b1, 1'b0, 1'b0, 1'b0, "run");

    // two empty cycles mid-line on line 0
    for (int i = 0; i < 60 && !(m_state == 1 && m_h == 1 && m_v == 0); i++)
      cycle(1'b1, 1'b0, 1'b0, 1'b0, "run");
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 1'b0, "uflow");
    repeat (20) cycle(1'b1, 1'b0, 1'b0, 1'b0, "uf_hold");
    cycle(1'b1, 1'b0, 1'b1, 1'b0, "uf_clr");
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, "uf_clr");
    for (int i = 0; i < 60 && !(m_h == 0 && m_v == 1); i++)
      cycle(1'b1, 1'b0, 1'b0, 1'b0, "run");
    cycle(1'b1, 1'b1, 1'b1, 1'b0, "uf_setclr");
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b0, "uf_setclr");

    // drop enable on line 1: frame completes, then idle
    for (int i = 0; i < 60 && !(m_h == 0 && m_v == 1); i++)
      cycle(1'b1, 1'b0, 1'b0, 1'b0, "run");
    for (int i = 0; i < 60 && m_state != 0; i++)
      cycle(1'b0, 1'b0, 1'b0, 1'b0, "stop");
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b0, "idle");

    // restart, then a short stop/re-enable inside the frame
    last_sof = -1;
    for (int i = 0; i < 60 && !(m_state == 1 && m_h == 0 && m_v == 1); i++)
      cycle(1'b1, 1'b0, 1'b0, 1'b0, "restart");
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, "stop_toggle");
    repeat (90) cycle(1'b1, 1'b0, 1'b0, 1'b0, "rerun");

    // one-cycle reset in the middle of an active line
    for (int i = 0; i < 60 && !(m_state == 1 && m_h == 2 && m_v == 0); i++)
      cycle(1'b1, 1'b0, 1'b0, 1'b0, "run");
    cycle(1'b1, 1'b0, 1'b0, 1'b1, "mid_reset");
    last_sof = -1;
    rel_cyc  = cyc;
    chk_rel  = 1'b1;
    repeat (45) cycle(1'b1, 1'b0, 1'b0, 1'b0, "after_reset");

    total++;
    assert (rel_seen === 1'b1) else begin
      bad++;
      $error("FAIL sof_after_reset_seen observed=%0b expected=1", rel_seen);
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Programmable raster timing generator and pixel-fetch sequencer that drives the 24-bit-to-8-bit VGA serializer. It runs in the pixel clock domain and produces hs, vs, active-low blank and 24-bit RGB data for the serializer's parallel inputs. Pixels come from a show-ahead pixel FIFO owned by the frame reader. Start and stop are frame-aligned, and underflow is detected and reported.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hs active level
- VS_POL, 0, vs active level
- UNDERFLOW_RGB, 24'h0000FF, pixel value driven when the FIFO is empty during active video

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- enable  in  1  run request; level-sensitive, frame-aligned
- fifo_data  in  24  RGB {R[23:16],G[15:8],B[7:0]}, valid while !fifo_empty (show-ahead)
- fifo_empty  in  1  FIFO empty
- fifo_rd  out  1  FIFO pop (combinational)
- data  out  24  registered pixel to serializer
- blank_n  out  1  registered; 1 = active video
- hs  out  1  registered horizontal sync
- vs  out  1  registered vertical sync
- sof  out  1  one-cycle pulse coincident with first active pixel of each frame
- busy  out  1  1 when not IDLE
- underflow  out  1  sticky underflow flag
- underflow_clr  in  1  clears underflow

## Operation
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counters h_cnt and v_cnt are 12-bit, each ranging 0..TOTAL-1.
- h_cnt wraps to 0 after H_TOTAL-1 and increments v_cnt on that wrap.
- v_cnt wraps to 0 after V_TOTAL-1.
- Region decodes, evaluated from current counters:
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hsync = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync = V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines.
- FSM states: IDLE, RUN, STOP.
  - IDLE: counters held at 0; outputs inactive. enable=1 → RUN. The first counted cycle is h=0, v=0.
  - RUN: counters advance every cycle. enable=0 → STOP.
  - STOP: counters keep advancing. At h=H_TOTAL-1 and v=V_TOTAL-1 → IDLE, with counters reset to 0. If enable=1 before that point → RUN, with no timing discontinuity.
- fifo_rd = (RUN|STOP) & active & !fifo_empty.
- Registered outputs, updated each cycle from the current state and counters:
  - blank_n <= active.
  - hs <= hsync ? HS_POL : !HS_POL.
  - vs <= vsync ? VS_POL : !VS_POL.
  - data <= active ? (fifo_empty ? UNDERFLOW_RGB : fifo_data) : 24'h0.
  - sof <= active && h_cnt==0 && v_cnt==0.
- underflow sets on any cycle where active && fifo_empty in RUN or STOP.
- underflow_clr clears the flag. If set and clear coincide, set wins.
- An underflow never stalls or slips timing; the pixel is replaced and the position advances.
- busy = (state != IDLE).

## Timing
- Reset values:
  - state IDLE; h_cnt=0, v_cnt=0.
  - data=0, blank_n=0, sof=0, underflow=0.
  - hs=!HS_POL, vs=!VS_POL.
  - fifo_rd=0, busy=0.
- Reset asserted mid-frame: at the next edge, all of the above values are restored. No partial line is completed.
- Latency:
  - Counter to registered outputs: 1 cycle.
  - fifo_rd is asserted in cycle N. The popped word appears on data with blank_n=1 at cycle N+1.
- The first RUN cycle has counters at 0. The first active pixel and sof appear 1 cycle after that.
- hs, vs, blank_n and data are mutually aligned, as the serializer requires.
- Since the serializer phase-locks on the hs rising edge, hs must never glitch. hs toggles exactly twice per line.

## Test plan
Small timing used throughout: H=4/1/2/1 (H_TOTAL=8), V=2/1/1/1 (V_TOTAL=5), HS_POL=VS_POL=0; 40-cycle frame.
- Reset then enable=1, FIFO always non-empty with incrementing words from 1:
  - blank_n=1 for 4 cycles per line on lines 0-1.
  - hs=0 at h_cnt 5-6, i.e. outputs 1 cycle later.
  - vs=0 for 8 cycles on line 3.
  - sof every 40 cycles; data sequence 1..8 per frame.
- FIFO empty for 2 active cycles mid-line:
  - data=0x0000FF on those cycles; no fifo_rd on those cycles.
  - underflow=1 and stays 1.
  - Timing is unchanged.
  - underflow_clr → underflow=0. underflow_clr together with a new underflow → underflow stays 1.
- enable=0 at v_cnt=1:
  - Frame completes.
  - busy drops after the h=7, v=4 cycle.
  - Outputs return to inactive; fifo_rd stays 0 while IDLE.
- enable toggled 0→1 within STOP: no gap; next sof exactly 40 cycles after previous.
- reset asserted mid-active-line for 1 cycle:
  - All outputs at reset values next cycle.
  - With enable held at 1, the first sof occurs 2 cycles after reset is released.
- Default 640x480 parameters, 2 frames:
  - 800×525 = 420000 cycles between sof pulses.
  - 307200 fifo_rd pulses per frame.
